// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32I pipeline.
// It formats store data into byte lanes and sign- or zero-extends load data.
// It drives a ready-handshaked data-memory port.
// While memory is busy it stalls the upstream pipeline.
// It registers results into the W-stage pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [2:0]  strCtrlM,
    input  logic [4:0]  rdM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] r2M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        misalignM,
    output logic        buserrM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  rdW,
    output logic [31:0] ALUoutW,
    output logic [31:0] ReadDataW
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;

    logic        w_access, w_misalign, w_go;
    logic        w_size_byte, w_size_half, w_size_word, w_signed;
    logic        w_stall, w_buserr, w_bubble;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    logic        r_regwrite, r_memtoreg;
    logic [4:0]  r_rd;
    logic [31:0] r_aluout, r_readdata;

    // Access decode and alignment check
    always_comb begin
        w_access    = MemWriteM | MemtoRegM;
        w_size_byte = (strCtrlM[1:0] == 2'b00);
        w_size_half = (strCtrlM[1:0] == 2'b01);
        w_size_word = ~w_size_byte & ~w_size_half;
        w_signed    = ~strCtrlM[2];
        w_misalign  = w_access & ((w_size_half & ALUoutM[0]) |
                                  (w_size_word & (|ALUoutM[1:0])));
        w_go        = w_access & ~w_misalign;
    end

    // Byte-lane enables and replicated store data; shared by loads and stores
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = r2M;
        if (w_size_byte) begin
            dmem_be    = 4'b0001 << ALUoutM[1:0];
            dmem_wdata = {4{r2M[7:0]}};
        end else if (w_size_half) begin
            dmem_be    = 4'b0011 << ALUoutM[1:0];
            dmem_wdata = {2{r2M[15:0]}};
        end
    end

    // Memory request signals; reset holds the request low even with a pending access
    always_comb begin
        dmem_req  = w_go & rst;
        dmem_we   = w_go & MemWriteM & rst;
        dmem_addr = {ALUoutM[31:2], 2'b00};
    end

    // Lane extraction and extension of the read word
    always_comb begin
        w_byte = 8'h00;
        unique case (ALUoutM[1:0])
            2'b00: w_byte = dmem_rdata[7:0];
            2'b01: w_byte = dmem_rdata[15:8];
            2'b10: w_byte = dmem_rdata[23:16];
            2'b11: w_byte = dmem_rdata[31:24];
        endcase
        w_half = ALUoutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (w_size_byte) begin
            w_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
        end else if (w_size_half) begin
            w_load_data = {{16{w_signed & w_half[15]}}, w_half};
        end else begin
            w_load_data = dmem_rdata;
        end
    end

    // Handshake FSM next state, wait counter, and stall/bus-error generation
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_buserr     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_go && !dmem_ready) begin
                    w_stall      = 1'b1;
                    w_state_next = StWait;
                    w_cnt_next   = CntW'(1);
                end
            end
            StWait: begin
                if (dmem_ready) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else if (r_cnt >= CntW'(TIMEOUT)) begin
                    // Give up: release the pipeline and drop the access
                    w_buserr     = 1'b1;
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Status outputs are forced low during reset
    always_comb begin
        stallM    = w_stall & rst;
        buserrM   = w_buserr & rst;
        misalignM = w_misalign & rst;
        w_bubble  = w_stall | w_buserr | w_misalign;
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // W-stage pipeline register; a bubble suppresses writeback and load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_aluout   <= '0;
            r_readdata <= '0;
        end else begin
            r_regwrite <= RegWriteM & ~w_bubble;
            r_memtoreg <= MemtoRegM & ~w_bubble;
            r_rd       <= rdM;
            r_aluout   <= ALUoutM;
            r_readdata <= (MemtoRegM & ~w_bubble) ? w_load_data : 32'h0;
        end
    end

    // W-stage register outputs
    always_comb begin
        RegWriteW = r_regwrite;
        MemtoRegW = r_memtoreg;
        rdW       = r_rd;
        ALUoutW   = r_aluout;
        ReadDataW = r_readdata;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// A reference model checks the outputs every cycle, and directed vectors pin hand-computed values.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk, rst;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic [2:0]  strCtrlM;
    logic [4:0]  rdM;
    logic [31:0] ALUoutM, r2M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stallM, misalignM, buserrM;
    logic        RegWriteW, MemtoRegW;
    logic [4:0]  rdW;
    logic [31:0] ALUoutW, ReadDataW;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .strCtrlM   (strCtrlM),
        .rdM        (rdM),
        .ALUoutM    (ALUoutM),
        .r2M        (r2M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .buserrM    (buserrM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .rdW        (rdW),
        .ALUoutW    (ALUoutW),
        .ReadDataW  (ReadDataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_m(input logic rw, input logic mw, input logic m2r, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] r2);
        RegWriteM = rw;
        MemWriteM = mw;
        MemtoRegM = m2r;
        strCtrlM  = f3;
        rdM       = rd;
        ALUoutM   = alu;
        r2M       = r2;
    endtask

    task automatic mem(input logic rdy, input logic [31:0] data);
        dmem_ready = rdy;
        dmem_rdata = data;
    endtask

    // Reference model: stall cycles spent on the current access, plus the expected W contents
    int          elapsed = 0;
    logic        e_rw = 1'b0, e_m2r = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_alu = '0, e_rdata = '0;

    always @(negedge clk) begin
        int          bytes, off;
        logic        acc, misal, go, stl, berr, bubble;
        logic [3:0]  ebe;
        logic [31:0] ew, lv, mask;
        if (!rst) begin
            chk("rst_stall", stallM, 0);
            chk("rst_req", dmem_req, 0);
            chk("rst_misalign", misalignM, 0);
            chk("rst_buserr", buserrM, 0);
            chk("rst_regwrite_w", RegWriteW, 0);
            chk("rst_readdata_w", ReadDataW, 0);
            elapsed = 0;
            e_rw = 0; e_m2r = 0; e_rd = '0; e_alu = '0; e_rdata = '0;
        end else begin
            chk("m_regwrite_w", RegWriteW, e_rw);
            chk("m_memtoreg_w", MemtoRegW, e_m2r);
            chk("m_rd_w", rdW, e_rd);
            chk("m_alu_w", ALUoutW, e_alu);
            chk("m_readdata_w", ReadDataW, e_rdata);

            acc = MemWriteM | MemtoRegM;
            case (strCtrlM[1:0])
                2'b00:   bytes = 1;
                2'b01:   bytes = 2;
                default: bytes = 4;
            endcase
            off   = int'(ALUoutM[1:0]);
            misal = acc && (off % bytes != 0);
            go    = acc && !misal;
            stl   = 0;
            berr  = 0;
            if (go && !dmem_ready) begin
                if (elapsed < int'(TIMEOUT)) begin
                    stl = 1;
                    elapsed++;
                end else begin
                    berr = 1;
                end
            end
            if (!stl) elapsed = 0;

            chk("m_stall", stallM, stl);
            chk("m_buserr", buserrM, berr);
            chk("m_misalign", misalignM, misal);
            chk("m_req", dmem_req, go);
            chk("m_we", dmem_we, go && MemWriteM);
            if (go) begin
                chk("m_addr", dmem_addr, ALUoutM & ~32'h3);
                ebe = 4'(((1 << bytes) - 1) << off);
                chk("m_be", dmem_be, ebe);
            end
            if (go && MemWriteM) begin
                for (int k = 0; k < 4; k++) ew[8*k +: 8] = r2M[8*(k % bytes) +: 8];
                chk("m_wdata", dmem_wdata, ew);
            end

            lv = dmem_rdata >> (8 * off);
            if (bytes < 4) begin
                mask = (32'h1 << (8 * bytes)) - 32'h1;
                lv   = lv & mask;
                if (!strCtrlM[2] && lv[8*bytes-1]) lv = lv | ~mask;
            end
            bubble  = stl || misal || berr;
            e_rw    = !bubble && RegWriteM;
            e_m2r   = !bubble && MemtoRegM;
            e_rd    = rdM;
            e_alu   = ALUoutM;
            e_rdata = (!bubble && MemtoRegM) ? lv : 32'h0;
        end
    end

    // Directed vectors with hand-computed expectations
    initial begin
        rst = 1'b0;
        set_m(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        mem(0, 32'h0);
        @(negedge clk); #1;
        chk("reset_stall", stallM, 0);
        chk("reset_regwrite_w", RegWriteW, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // LW 0x100, ready in the same cycle
        set_m(1, 0, 1, 3'b010, 5'd3, 32'h100, 32'h0);
        mem(1, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("lw_be", dmem_be, 4'b1111);
        chk("lw_stall", stallM, 0);
        @(posedge clk); #1;
        // LB 0x103
        set_m(1, 0, 1, 3'b000, 5'd4, 32'h103, 32'h0);
        mem(1, 32'h80AA55CC);
        @(negedge clk); #1;
        chk("lw_readdata", ReadDataW, 32'hDEADBEEF);
        chk("lw_memtoreg", MemtoRegW, 1);
        chk("lw_regwrite", RegWriteW, 1);
        chk("lb_be", dmem_be, 4'b1000);
        @(posedge clk); #1;
        // LBU 0x103
        set_m(1, 0, 1, 3'b100, 5'd4, 32'h103, 32'h0);
        @(negedge clk); #1;
        chk("lb_readdata", ReadDataW, 32'hFFFFFF80);
        @(posedge clk); #1;
        // SH 0x202, ready after three wait cycles
        set_m(0, 1, 0, 3'b001, 5'd0, 32'h202, 32'h1234ABCD);
        mem(0, 32'h0);
        @(negedge clk); #1;
        chk("lbu_readdata", ReadDataW, 32'h00000080);
        for (int i = 0; i < 3; i++) begin
            chk("sh_stall", stallM, 1);
            chk("sh_we", dmem_we, 1);
            chk("sh_be", dmem_be, 4'b1100);
            chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
            @(posedge clk); #1;
            if (i == 2) mem(1, 32'h0);
            @(negedge clk); #1;
        end
        chk("sh_done_stall", stallM, 0);
        @(posedge clk); #1;
        // SW 0x201: misaligned
        set_m(0, 1, 0, 3'b010, 5'd0, 32'h201, 32'h55);
        @(negedge clk); #1;
        chk("sh_regwrite_w", RegWriteW, 0);
        chk("sw_mis_req", dmem_req, 0);
        chk("sw_mis_pulse", misalignM, 1);
        chk("sw_mis_stall", stallM, 0);
        @(posedge clk); #1;
        // LH 0x101: misaligned load with a write-back request
        set_m(1, 0, 1, 3'b001, 5'd6, 32'h101, 32'h0);
        @(negedge clk); #1;
        chk("lh_mis_pulse", misalignM, 1);
        @(posedge clk); #1;
        set_m(1, 0, 0, 3'b000, 5'd9, 32'h55, 32'h0);
        @(negedge clk); #1;
        chk("lh_mis_bubble", RegWriteW, 0);
        chk("mis_pulse_end", misalignM, 0);
        @(posedge clk); #1;

        // LW 0x300 with no ready: stall for the full timeout, then a bus error
        set_m(1, 0, 1, 3'b010, 5'd7, 32'h300, 32'h0);
        mem(0, 32'h0);
        @(negedge clk); #1;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            chk("to_stall", stallM, 1);
            chk("to_no_buserr", buserrM, 0);
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        chk("to_buserr", buserrM, 1);
        chk("to_release", stallM, 0);
        @(posedge clk); #1;
        set_m(1, 0, 0, 3'b000, 5'd8, 32'h42, 32'h0);
        @(negedge clk); #1;
        chk("to_buserr_end", buserrM, 0);
        chk("to_bubble", RegWriteW, 0);
        chk("to_idle_stall", stallM, 0);
        @(posedge clk); #1;
        set_m(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("to_after_rd", rdW, 5'd8);
        chk("to_after_rw", RegWriteW, 1);
        @(posedge clk); #1;

        // LW 0x400 stuck in WAIT, then an asynchronous reset
        set_m(1, 0, 1, 3'b010, 5'd10, 32'h400, 32'h0);
        mem(0, 32'h0);
        @(negedge clk); #1;
        chk("wait_stall_a", stallM, 1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("wait_stall_b", stallM, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_stall", stallM, 0);
        chk("arst_req", dmem_req, 0);
        chk("arst_rw", RegWriteW, 0);
        chk("arst_alu", ALUoutW, 32'h0);
        chk("arst_rd", rdW, 5'd0);
        chk("arst_rdata", ReadDataW, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_m(1, 0, 0, 3'b000, 5'd5, 32'd7, 32'h0);
        @(negedge clk); #1;
        chk("add_stall", stallM, 0);
        @(posedge clk); #1;
        set_m(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk("add_rw", RegWriteW, 1);
        chk("add_rd", rdW, 5'd5);
        chk("add_alu", ALUoutW, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Consumes the M-stage pipeline signals from execute and drives a ready-handshaked data-memory port.
- Formats stores into byte lanes and sign/zero-extends loads.
- Stalls the pipeline while memory is busy.
- Registers results into the W-stage pipeline register for writeback.

Parameters:
- TIMEOUT, 16, max cycles to wait for dmem_ready before abandoning the access (must be >= 2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteM  in  1  register write enable from execute
- MemWriteM  in  1  store
- MemtoRegM  in  1  load (writeback from memory)
- strCtrlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rdM  in  5  destination register
- ALUoutM  in  32  effective address / ALU result
- r2M  in  32  forwarded store data
- dmem_req  out  1  access request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address, bits [1:0] forced to 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ready  in  1  access complete this cycle; rdata valid
- dmem_rdata  in  32  read word
- stallM  out  1  freeze F/D/E/M registers
- misalignM  out  1  one-cycle pulse, misaligned access dropped
- buserrM  out  1  one-cycle pulse, access timed out
- RegWriteW  out  1  registered write enable
- MemtoRegW  out  1  registered
- rdW  out  5  registered
- ALUoutW  out  32  registered
- ReadDataW  out  32  registered, extended load data

Behaviour:
- Access = MemWriteM | MemtoRegM.
- Misaligned when:
  - H/HU with ALUoutM[0]=1, or
  - W with ALUoutM[1:0]!=0.
- Misaligned access:
  - dmem_req=0, misalignM=1 for that cycle, no stall.
  - W register loads a bubble: RegWriteW=0, MemtoRegW=0.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{r2M[7:0]}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{r2M[15:0]}}.
  - SW: be = 1111, wdata = r2M.
- Load lanes:
  - dmem_be is computed the same way for loads.
  - Byte/half is selected from dmem_rdata by addr[1:0].
  - Sign-extended for B/H, zero-extended for BU/HU.
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are combinational from M inputs.
  - They are held stable across WAIT because stallM freezes the upstream register.
- FSM states: IDLE, WAIT.
  - IDLE, aligned access, dmem_ready=1: completes in the same cycle. stallM=0. W register captures the result at the next edge.
  - IDLE, aligned access, dmem_ready=0: stallM=1. Go to WAIT. Clear the timeout counter to 1.
  - WAIT, dmem_ready=1: stallM=0. Capture the result. Go to IDLE.
  - WAIT, dmem_ready=0: stallM=1, counter++.
  - WAIT, counter reaches TIMEOUT with no ready:
    - buserrM pulses and stallM=0.
    - W register loads a bubble; go to IDLE.
- While stallM=1, the W register loads a bubble every edge (RegWriteW=0), so no duplicate writeback.
- Non-memory instructions pass straight through with one-cycle latency and stallM=0:
  - RegWriteW, rdW and ALUoutW are registered.
  - ReadDataW = 0.
- Reset (rst=0, asynchronous, any state including mid-WAIT):
  - FSM = IDLE, counter = 0.
  - All W outputs = 0.
  - stallM, misalignM and buserrM = 0.
  - dmem_req = 0 while in reset.
  - An outstanding access is abandoned; the memory must tolerate a dropped request.

Test Plan:
- LW, addr 0x100, ready=1 same cycle, rdata 0xDEADBEEF → be=1111, no stall; next edge ReadDataW=0xDEADBEEF, MemtoRegW=1, RegWriteW=1.
- LB, addr 0x103, rdata 0x80AA55CC → be=1000, ReadDataW=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH, addr 0x202, r2M=0x1234ABCD, ready after 3 cycles → dmem_we=1, be=1100, wdata=0xABCDABCD; stallM high 3 cycles; then RegWriteW=0.
- SW, addr 0x201 → dmem_req=0, misalignM pulses 1 cycle, W bubble, no stall.
- LW with ready never asserted, TIMEOUT=16 → stallM high 16 cycles, buserrM pulses, FSM returns to IDLE, W bubble.
- rst asserted low during WAIT → stallM, dmem_req and all W outputs go 0 immediately; after release, an ADD result (RegWriteM=1, rd=5, ALUout=7) appears on W one cycle later.
